dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 62 ++++++
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory it fronts.
// Holds the arbiter FSM state encoding and the default memory geometry.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int DMEM_ADDR_W = 14;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_DEPTH  = 100;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker: the last owner keeps a contested grant
// until it has taken MAX_BURST grants in a row, then the other port wins.
module rr_arb2
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   arb_state_t       state;
   logic [CNT_W-1:0] burst_cnt;
   logic             keep_owner;

   // Grants are purely combinational so a requester is served in its own cycle.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      keep_owner = (burst_cnt < BURST_MAX);
      if (rst_n) begin
         if (req0 && !req1) begin
            gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            case (state)
               OWN0:    if (keep_owner) gnt0 = 1'b1; else gnt1 = 1'b1;
               OWN1:    if (keep_owner) gnt1 = 1'b1; else gnt0 = 1'b1;
               default: gnt0 = 1'b1;
            endcase
         end
      end
   end

   // Counter saturates at MAX_BURST: a lone requester may hold the port forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         burst_cnt <= '0;
      end else if (gnt0) begin
         state     <= OWN0;
         burst_cnt <= (state != OWN0) ? CNT_W'(1) :
                      (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
      end else if (gnt1) begin
         state     <= OWN1;
         burst_cnt <= (state != OWN1) ? CNT_W'(1) :
                      (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
      end else begin
         state     <= IDLE;
         burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port front end for a single-ported asynchronous-read data memory:
// round-robin grant, address/data mux and a one-cycle registered read response.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int DEPTH     = DMEM_DEPTH,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic              gnt0, gnt1, any_gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we, in_range;
   logic [DATA_W-1:0] resp_data;

   rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req0 (p0_req),
      .req1 (p1_req),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   assign p0_gnt = gnt0;
   assign p1_gnt = gnt1;

   // Memory bus is parked at zero when nobody is granted.
   always_comb begin
      any_gnt   = gnt0 | gnt1;
      sel_addr  = gnt1 ? p1_addr  : p0_addr;
      sel_wdata = gnt1 ? p1_wdata : p0_wdata;
      sel_we    = gnt1 ? p1_we    : p0_we;
      in_range  = ({1'b0, sel_addr} < DEPTH_LIM);
      mem_a     = any_gnt ? sel_addr  : '0;
      mem_wd    = any_gnt ? sel_wdata : '0;
      mem_we    = any_gnt & sel_we & in_range;
      resp_data = in_range ? mem_rd : '0;
   end

   // rdata holds between responses; err only qualifies the rvalid cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rvalid <= 1'b0;
         p0_err    <= 1'b0;
         p0_rdata  <= '0;
         p1_rvalid <= 1'b0;
         p1_err    <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= gnt0;
         p0_err    <= gnt0 & ~in_range;
         p1_rvalid <= gnt1;
         p1_err    <= gnt1 & ~in_range;
         if (gnt0) p0_rdata <= resp_data;
         if (gnt1) p1_rdata <= resp_data;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner case and a
// randomized run compared against a grant-history reference model.
module tb_dmem_arbiter;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 32;
   localparam int DEPTH     = 100;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              p0_req, p0_we, p1_req, p1_we;
   logic [ADDR_W-1:0] p0_addr, p1_addr;
   logic [DATA_W-1:0] p0_wdata, p1_wdata;
   logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_wd, mem_rd;
   logic              mem_we;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   // Environment memory: asynchronous read, synchronous write.
   logic [DATA_W-1:0] env_mem [0:255];
   assign mem_rd = (mem_a < 14'd256) ? env_mem[mem_a[7:0]] : 32'hBAD0BAD0;
   always @(posedge clk) if (mem_we && mem_a < 14'd256) env_mem[mem_a[7:0]] <= mem_wd;

   // Reference model state.
   logic [DATA_W-1:0] m_mem [0:255];
   bit                m_rv  [2];
   logic [DATA_W-1:0] m_rd  [2];
   bit                m_err [2];
   int                hist[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Contested grant: p0 from idle, else the last owner until it has MAX_BURST in a row.
   task automatic model_grant(input bit r0, input bit r1, output bit g0, output bit g1);
      int last, run, winner;
      g0 = 0; g1 = 0;
      if (r0 && !r1) g0 = 1;
      else if (r1 && !r0) g1 = 1;
      else if (r0 && r1) begin
         if (hist.size() == 0) winner = 0;
         else begin
            last = hist[hist.size()-1];
            run  = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
            winner = (run < MAX_BURST) ? last : 1 - last;
         end
         if (winner == 0) g0 = 1; else g1 = 1;
      end
   endtask

   task automatic set_in(input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input int a1, input logic [31:0] d1);
      p0_req = r0; p0_we = w0; p0_addr = ADDR_W'(a0); p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = ADDR_W'(a1); p1_wdata = d1;
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin m_rv[p] = 0; m_rd[p] = '0; m_err[p] = 0; end
      hist.delete();
   endtask

   // Called just after a falling edge with inputs applied; ends on the next falling edge.
   task automatic cycle(input string tag);
      bit g0, g1, inr, we;
      int p;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      #1;
      model_grant(p0_req, p1_req, g0, g1);
      a   = g1 ? p1_addr : (g0 ? p0_addr : '0);
      wd  = g1 ? p1_wdata : p0_wdata;
      inr = (int'(a) < DEPTH);
      we  = ((g0 && p0_we) || (g1 && p1_we)) && inr;
      chk({tag, ".p0_gnt"}, 64'(p0_gnt), 64'(g0));
      chk({tag, ".p1_gnt"}, 64'(p1_gnt), 64'(g1));
      chk({tag, ".mem_a"}, 64'(mem_a), 64'(a));
      chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
      if (g0 || g1) chk({tag, ".mem_wd"}, 64'(mem_wd), 64'(wd));
      chk({tag, ".p0_rvalid"}, 64'(p0_rvalid), 64'(m_rv[0]));
      chk({tag, ".p0_rdata"}, 64'(p0_rdata), 64'(m_rd[0]));
      chk({tag, ".p0_err"}, 64'(p0_err), 64'(m_err[0]));
      chk({tag, ".p1_rvalid"}, 64'(p1_rvalid), 64'(m_rv[1]));
      chk({tag, ".p1_rdata"}, 64'(p1_rdata), 64'(m_rd[1]));
      chk({tag, ".p1_err"}, 64'(p1_err), 64'(m_err[1]));
      @(posedge clk);
      m_rv[0] = 0; m_rv[1] = 0; m_err[0] = 0; m_err[1] = 0;
      if (g0 || g1) begin
         p = g1 ? 1 : 0;
         m_rv[p]  = 1;
         m_rd[p]  = inr ? m_mem[a[7:0]] : '0;
         m_err[p] = !inr;
         if (we) m_mem[a[7:0]] = wd;
         hist.push_back(p);
      end else begin
         hist.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".gnt"}, 64'({p0_gnt, p1_gnt}), 64'd0);
      chk({tag, ".rvalid"}, 64'({p0_rvalid, p1_rvalid}), 64'd0);
      chk({tag, ".err"}, 64'({p0_err, p1_err}), 64'd0);
      chk({tag, ".p0_rdata"}, 64'(p0_rdata), 64'd0);
      chk({tag, ".p1_rdata"}, 64'(p1_rdata), 64'd0);
      chk({tag, ".mem"}, 64'({mem_we, mem_a}), 64'd0);
      chk({tag, ".mem_wd"}, 64'(mem_wd), 64'd0);
   endtask

   typedef struct {
      bit r0; bit w0; int a0; logic [31:0] d0;
      bit r1; bit w1; int a1; logic [31:0] d1;
      bit eg0; bit eg1; bit ewe;
   } vec_t;

   vec_t tbl[$];

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 32'(i + 2);
         m_mem[i]   = 32'(i + 2);
      end
      model_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);

      //        r0 w0 a0   d0            r1 w1 a1 d1            g0 g1 we
      tbl.push_back('{1, 0, 8,   0,            0, 0, 0, 0,            1, 0, 0}); // lone p0 read
      tbl.push_back('{0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0});
      tbl.push_back('{0, 0, 0,   0,            1, 1, 5, 32'hDEADBEEF, 0, 1, 1}); // p1 write
      tbl.push_back('{1, 0, 5,   0,            0, 0, 0, 0,            1, 0, 0}); // p0 read back
      tbl.push_back('{0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0});
      for (int k = 0; k < 9; k++) begin                                         // contested run
         tbl.push_back('{1, 0, 1, 0, 1, 0, 2, 0, (k < 4 || k == 8), (k >= 4 && k < 8), 0});
      end
      tbl.push_back('{0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0});
      tbl.push_back('{1, 1, 100, 32'h12345678, 0, 0, 0, 0,            1, 0, 0}); // out of range
      tbl.push_back('{0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0});
      tbl.push_back('{0, 0, 0,   0,            1, 0, 3, 0,            0, 1, 0}); // p1 burst cnt 1
      tbl.push_back('{1, 0, 4,   0,            1, 0, 3, 0,            0, 1, 0}); // p1 cnt 2
      tbl.push_back('{1, 0, 4,   0,            0, 0, 3, 0,            1, 0, 0}); // p1 drops
      tbl.push_back('{0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0});

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset_state");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         set_in(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
         #1;
         chk($sformatf("vec%0d.gnt", i), 64'({p0_gnt, p1_gnt}), 64'({tbl[i].eg0, tbl[i].eg1}));
         chk($sformatf("vec%0d.mem_we", i), 64'(mem_we), 64'(tbl[i].ewe));
         cycle($sformatf("vec%0d", i));
      end
      chk("mem5_written", 64'(env_mem[5]), 64'h00000000DEADBEEF);
      chk("mem100_untouched", 64'(env_mem[100]), 64'd102);

      // Reset asserted while a read is being granted.
      set_in(1, 0, 8, 0, 0, 0, 0, 0);
      #1;
      chk("rst_pre.p0_gnt", 64'(p0_gnt), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      model_reset();
      @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cycle("post_rst");
      cycle("post_rst2");

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int a0, a1;
         a0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 16383)) : int'($urandom_range(0, 127));
         a1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 16383)) : int'($urandom_range(0, 127));
         set_in($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a0, $urandom,
                $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a1, $urandom);
         cycle($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
